// File: rtl/am_dsp_pkg.sv
// Shared widths and FSM state type for the AM envelope post-processing path.
package am_dsp_pkg;
    localparam int SQ_W   = 16;
    localparam int MAG_W  = 8;
    localparam int Q_FRAC = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQRT = 2'd1,
        DCR  = 2'd2,
        OUT  = 2'd3
    } am_state_t;
endpackage

// File: rtl/isqrt16_serial.sv
// Bit-serial restoring integer square root: one root bit per cycle, MSB first.
module isqrt16_serial
    import am_dsp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SQ_W-1:0]  radicand,
    output logic             done,
    output logic [MAG_W-1:0] root
);
    logic [SQ_W-1:0] rad;
    logic [7:0]      rem;
    logic [2:0]      cnt;
    logic            busy;
    logic [9:0]      rem_sh;
    logic [9:0]      trial;
    logic            ge;

    // Partial remainder never exceeds 2*root, so 8 bits hold it between steps.
    assign rem_sh = {rem, rad[SQ_W-1 -: 2]};
    assign trial  = {root, 2'b01};
    assign ge     = (rem_sh >= trial);
    assign done   = busy && (cnt == 3'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rad  <= '0;
            rem  <= '0;
            root <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            rad  <= radicand;
            rem  <= '0;
            root <= '0;
            cnt  <= 3'd7;
            busy <= 1'b1;
        end else if (busy) begin
            rad  <= {rad[SQ_W-3:0], 2'b00};
            rem  <= 8'(ge ? (rem_sh - trial) : rem_sh);
            root <= {root[MAG_W-2:0], ge};
            cnt  <= cnt - 3'd1;
            if (cnt == 3'd0)
                busy <= 1'b0;
        end
    end
endmodule

// File: rtl/am_envelope_post.sv
// AM envelope post-processing: sqrt of I^2+Q^2, then leaky DC removal to Q8.8 audio.
//  state | meaning
//  IDLE  | ready for a sample; square_in captured by the sqrt unit on sample_valid
//  SQRT  | 8 root-bit iterations, counter 7 down to 0
//  DCR   | subtract DC estimate, saturate to audio_out, update DC estimate
//  OUT   | pulse audio_valid, return to IDLE
module am_envelope_post
    import am_dsp_pkg::*;
#(
    parameter int DC_SHIFT = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_valid,
    input  logic [SQ_W-1:0]    square_in,
    output logic               ready,
    output logic signed [15:0] audio_out,
    output logic               audio_valid,
    output logic               overrun
);
    am_state_t         state;
    logic [2:0]        counter;
    logic [15:0]       dc_est;
    logic              sqrt_start;
    logic              sqrt_done;
    logic [MAG_W-1:0]  mag;
    logic signed [16:0] diff;
    logic [15:0]       dc_step;
    logic [15:0]       diff_sat;

    assign sqrt_start = (state == IDLE) && sample_valid;

    isqrt16_serial u_sqrt (
        .clk      (clk),
        .rst      (rst),
        .start    (sqrt_start),
        .radicand (square_in),
        .done     (sqrt_done),
        .root     (mag)
    );

    assign diff = $signed({1'b0, mag, {Q_FRAC{1'b0}}}) - $signed({1'b0, dc_est});
    // The true sum stays within 0..65280, so modulo-2^16 addition is exact.
    assign dc_step = 16'(diff >>> DC_SHIFT);

    always_comb begin
        diff_sat = diff[15:0];
        if (diff[16:15] == 2'b01)
            diff_sat = 16'h7fff;
        else if (diff[16:15] == 2'b10)
            diff_sat = 16'h8000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ready       <= 1'b1;
            audio_out   <= '0;
            audio_valid <= 1'b0;
            overrun     <= 1'b0;
            dc_est      <= '0;
            counter     <= '0;
        end else begin
            audio_valid <= 1'b0;
            if (sample_valid && !ready)
                overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (sample_valid) begin
                        state   <= SQRT;
                        ready   <= 1'b0;
                        counter <= 3'd7;
                    end
                end
                SQRT: begin
                    if (counter == 3'd0 && sqrt_done)
                        state <= DCR;
                    else
                        counter <= counter - 3'd1;
                end
                DCR: begin
                    audio_out <= diff_sat;
                    dc_est    <= dc_est + dc_step;
                    state     <= OUT;
                end
                OUT: begin
                    audio_valid <= 1'b1;
                    ready       <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_am_envelope_post.sv
// Self-checking bench for am_envelope_post against a cycle-indexed behavioural model.
module tb_am_envelope_post;
    localparam int DC_SHIFT = 6;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               sample_valid = 1'b0;
    logic [15:0]        square_in = '0;
    logic               ready;
    logic signed [15:0] audio_out;
    logic               audio_valid;
    logic               overrun;

    always #5 clk = ~clk;

    am_envelope_post #(.DC_SHIFT(DC_SHIFT)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .square_in    (square_in),
        .ready        (ready),
        .audio_out    (audio_out),
        .audio_valid  (audio_valid),
        .overrun      (overrun)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: edge index, accepted-sample edge, and expected outputs after each edge.
    int e        = 0;
    int acc_edge = -1;
    int acc_x    = 0;
    int m_audio  = 0;
    int m_dc     = 0;
    bit m_valid  = 1'b0;
    bit m_ovr    = 1'b0;
    bit m_ready  = 1'b1;

    function automatic int isqrt_ref(int x);
        int r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    function automatic int floor_div(int a, int d);
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, e);
        end
    endtask

    task automatic model_step();
        int d;
        e++;
        if (rst) begin
            acc_edge = -1;
            m_audio  = 0;
            m_dc     = 0;
            m_ovr    = 1'b0;
            m_valid  = 1'b0;
            m_ready  = 1'b1;
            return;
        end
        m_valid = 1'b0;
        if (acc_edge >= 0 && e == acc_edge + 9) begin
            d = isqrt_ref(acc_x) * 256 - m_dc;
            m_audio = (d > 32767) ? 32767 : ((d < -32768) ? -32768 : d);
            m_dc = m_dc + floor_div(d, 1 << DC_SHIFT);
        end
        if (acc_edge >= 0 && e == acc_edge + 10)
            m_valid = 1'b1;
        if (sample_valid) begin
            if (acc_edge < 0 || e >= acc_edge + 11) begin
                acc_edge = e;
                acc_x    = int'(square_in);
            end else begin
                m_ovr = 1'b1;
            end
        end
        m_ready = (acc_edge < 0) || (e >= acc_edge + 10);
    endtask

    task automatic compare();
        check("ready", int'(ready), int'(m_ready));
        check("audio_valid", int'(audio_valid), int'(m_valid));
        check("audio_out", int'(audio_out), m_audio);
        check("overrun", int'(overrun), int'(m_ovr));
        check("dc_est", int'(dut.dc_est), m_dc);
        if (m_valid)
            check("mag", int'(dut.u_sqrt.root), isqrt_ref(acc_x));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    task automatic send(input int x);
        sample_valid = 1'b1;
        square_in    = 16'(x);
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int prev;
    int k;

    initial begin
        do_reset();
        check("rst_ready", int'(ready), 1);
        check("rst_audio", int'(audio_out), 0);
        check("rst_valid", int'(audio_valid), 0);
        check("rst_overrun", int'(overrun), 0);

        send(10000);
        repeat (9) tick();
        check("lit_audio_10000", int'(audio_out), 25600);
        check("lit_dc_400", int'(dut.dc_est), 400);
        check("lit_valid_not_yet", int'(audio_valid), 0);
        tick();
        check("lit_valid_10", int'(audio_valid), 1);
        tick();
        check("lit_valid_one_cycle", int'(audio_valid), 0);

        do_reset();
        send(65535);
        repeat (10) tick();
        check("lit_sat_65535", int'(audio_out), 32767);
        check("lit_mag_255", int'(dut.u_sqrt.root), 255);

        do_reset();
        send(0);
        repeat (10) tick();
        check("lit_zero", int'(audio_out), 0);
        check("lit_zero_valid", int'(audio_valid), 1);

        // Second strobe five cycles after acceptance must be dropped.
        do_reset();
        send(3600);
        repeat (4) tick();
        send(100);
        check("lit_overrun", int'(overrun), 1);
        repeat (5) tick();
        check("lit_first_kept", int'(audio_out), 15360);
        check("lit_first_valid", int'(audio_valid), 1);
        tick();

        // Reset in the fourth SQRT cycle aborts the sample.
        do_reset();
        send(10000);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("lit_abort_ready", int'(ready), 1);
        check("lit_abort_audio", int'(audio_out), 0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("lit_abort_no_valid", int'(audio_valid), 0);
        end
        send(10000);
        repeat (10) tick();
        check("lit_after_abort", int'(audio_out), 25600);
        tick();

        // Constant envelope decays towards zero as the DC estimate converges.
        do_reset();
        prev = 0;
        for (int i = 0; i < 2000; i++) begin
            send(2500);
            repeat (10) tick();
            if (i == 0)
                check("lit_decay_start", int'(audio_out), 12800);
            else
                check("decay_monotonic", int'(int'(audio_out) <= prev), 1);
            prev = int'(audio_out);
        end
        check("decay_end_small", int'(prev < 64 && prev > -64), 1);

        // Randomized traffic with sqrt boundary values and stray strobes.
        do_reset();
        for (int i = 0; i < 20000; i++) begin
            sample_valid = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 3))
                0: begin
                    k = $urandom_range(0, 255);
                    square_in = 16'(k * k);
                end
                1: begin
                    k = $urandom_range(1, 255);
                    square_in = 16'(k * k - 1);
                end
                2: square_in = 16'hffff;
                default: square_in = 16'($urandom_range(0, 65535));
            endcase
            rst = ($urandom_range(0, 1999) == 0);
            tick();
        end
        rst = 1'b0;
        sample_valid = 1'b0;
        repeat (12) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
